// File: rtl/preproc_pkt_pkg.sv
// Shared types and constants for the sample packetizer.
// Packs two sign-extended samples per 32-bit AXI4-Stream word.
package preproc_pkt_pkg;

    localparam int PACK_WIDTH       = 16;
    localparam int WORD_WIDTH       = 32;
    localparam int PKT_LEN_WIDTH    = 16;
    localparam int DEF_SAMPLE_WIDTH = 14;
    localparam int DEF_FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } pkt_state_t;

    typedef struct packed {
        logic                  last;
        logic [WORD_WIDTH-1:0] data;
    } pkt_word_t;

endpackage

// File: rtl/pkt_sync_fifo.sv
// Synchronous FIFO with occupancy-counter full/empty flags.
// A push while full is still accepted when a pop happens in the same cycle.
module pkt_sync_fifo
    import preproc_pkt_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic             wr_en
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             empty;
    logic             rd_en;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign rd_en  = !empty && rd_ready;
    assign wr_en  = push && (!full || rd_en);
    assign rvalid = !empty;
    assign rdata  = mem[rd_ptr];

    // Memory is reset so the head word reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/preproc_sample_packetizer.sv
// Packs sample pairs into 32-bit words and frames fixed-length packets
// onto an AXI4-Stream master through a small buffering FIFO.
module preproc_sample_packetizer
    import preproc_pkt_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SAMPLE_WIDTH-1:0]  s_data_i,
    input  logic                     s_valid_i,
    input  logic                     enable_i,
    input  logic [PKT_LEN_WIDTH-1:0] pkt_len_i,
    input  logic                     clr_i,
    output logic [WORD_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     overflow_o,
    output logic [15:0]              drop_count_o,
    output logic [15:0]              pkt_count_o
);

    pkt_state_t               state;
    pkt_state_t               state_nxt;
    logic [PKT_LEN_WIDTH-1:0] wcnt;
    logic [PKT_LEN_WIDTH-1:0] len_q;
    logic [PACK_WIDTH-1:0]    low_q;
    logic [PACK_WIDTH-1:0]    smp_ext;
    logic                     cap_low;
    logic                     cap_high;
    logic                     latch_len;
    logic                     is_last;
    logic                     push_q;
    pkt_word_t                word_q;
    pkt_word_t                head;
    logic                     fifo_wr;
    logic                     drop;

    assign smp_ext = PACK_WIDTH'($signed(s_data_i));
    assign is_last = (wcnt == len_q - PKT_LEN_WIDTH'(1));

    // Disable is only honoured on a packet boundary.
    always_comb begin
        state_nxt = state;
        cap_low   = 1'b0;
        cap_high  = 1'b0;
        latch_len = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable_i) begin
                    latch_len = 1'b1;
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (wcnt == '0 && !enable_i) begin
                    state_nxt = IDLE;
                end else if (s_valid_i) begin
                    cap_low   = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (s_valid_i) begin
                    cap_high  = 1'b1;
                    state_nxt = LOW;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            wcnt   <= '0;
            len_q  <= '0;
            low_q  <= '0;
            push_q <= 1'b0;
            word_q <= '0;
        end else begin
            state  <= state_nxt;
            push_q <= cap_high;
            if (latch_len) begin
                len_q <= (pkt_len_i == '0) ? PKT_LEN_WIDTH'(1) : pkt_len_i;
            end
            if (cap_low) begin
                low_q <= smp_ext;
            end
            if (cap_high) begin
                word_q.last <= is_last;
                word_q.data <= {smp_ext, low_q};
                wcnt        <= is_last ? '0 : wcnt + PKT_LEN_WIDTH'(1);
            end
        end
    end

    pkt_sync_fifo #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_q),
        .wdata    (word_q),
        .rd_ready (m_axis_tready),
        .rdata    (head),
        .rvalid   (m_axis_tvalid),
        .wr_en    (fifo_wr)
    );

    assign m_axis_tdata = head.data;
    assign m_axis_tlast = head.last;
    assign drop         = push_q && !fifo_wr;

    // A clear in the same cycle as a drop takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_o   <= 1'b0;
            drop_count_o <= '0;
            pkt_count_o  <= '0;
        end else begin
            if (clr_i) begin
                overflow_o   <= 1'b0;
                drop_count_o <= '0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                if (drop_count_o != 16'hFFFF) begin
                    drop_count_o <= drop_count_o + 16'd1;
                end
            end
            if (push_q && fifo_wr && word_q.last) begin
                pkt_count_o <= pkt_count_o + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_preproc_sample_packetizer.sv
// Self-checking bench for preproc_sample_packetizer.
// Expected words come from a pair-packing reference model over sent samples.
module tb_preproc_sample_packetizer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] pkt_len = '0;
    logic        clr = 1'b0;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready = 1'b0;
    logic        tlast;
    logic        overflow;
    logic [15:0] drop_count;
    logic [15:0] pkt_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [13:0] smp[$];
    logic [32:0] exp_q[$];
    logic [32:0] rx[$];

    preproc_sample_packetizer dut (
        .clk           (clk),
        .rst           (rst),
        .s_data_i      (s_data),
        .s_valid_i     (s_valid),
        .enable_i      (enable),
        .pkt_len_i     (pkt_len),
        .clr_i         (clr),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .overflow_o    (overflow),
        .drop_count_o  (drop_count),
        .pkt_count_o   (pkt_count)
    );

    always #5 clk = ~clk;

    // Inputs change on negedge; handshake sampled mid low phase.
    always @(negedge clk) begin
        #2;
        if (tvalid && tready) rx.push_back({tlast, tdata});
    end

    function automatic logic [15:0] sext(input logic [13:0] s);
        int v;
        v = $signed(s);
        return v[15:0];
    endfunction

    function automatic void build_model(input int len);
        int l;
        l = (len == 0) ? 1 : len;
        exp_q.delete();
        for (int k = 0; 2 * k + 1 < smp.size(); k++) begin
            exp_q.push_back({((k + 1) % l) == 0,
                             sext(smp[2*k+1]), sext(smp[2*k])});
        end
    endfunction

    task automatic send(input logic [13:0] s, input bit rec);
        @(negedge clk);
        s_data  = s;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        if (rec) smp.push_back(s);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        enable  = 1'b0;
        clr     = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx.delete();
        smp.delete();
    endtask

    task automatic wait_rx(input int n);
        for (int i = 0; i < 400 && rx.size() < n; i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic cmp_words(input string tag);
        logic [32:0] obs;
        n_cmp++;
        if (rx.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL %s count: got %0d want %0d", tag, rx.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            obs = (k < rx.size()) ? rx[k] : 'x;
            n_cmp++;
            if (obs !== exp_q[k]) begin
                n_err++;
                $display("FAIL %s word%0d: got %h want %h", tag, k, obs, exp_q[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tvalid, tlast, tdata, overflow, drop_count, pkt_count} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got %b %b %h %b %h %h want all 0",
                     tvalid, tlast, tdata, overflow, drop_count, pkt_count);
        end
        do_reset();
        n_cmp++;
        if (tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL reset tvalid: got %b want 0", tvalid);
        end
    endtask

    task automatic test_packing();
        do_reset();
        tready  = 1'b1;
        pkt_len = 16'd4;
        enable  = 1'b1;
        @(negedge clk);
        send(14'h3FFF, 1);
        send(14'h0002, 1);
        send(14'h2000, 1);
        send(14'h1FFF, 1);
        repeat (4) send(14'($urandom), 1);
        wait_rx(4);
        build_model(4);
        cmp_words("packing");
        n_cmp++;
        if (rx.size() < 2 || rx[0][31:0] !== 32'h0002FFFF || rx[1][31:0] !== 32'h1FFFE000) begin
            n_err++;
            $display("FAIL packing const: got %0d words want 0002ffff 1fffe000", rx.size());
        end
        n_cmp++;
        if (pkt_count !== 16'd1) begin
            n_err++;
            $display("FAIL packing pkt_count: got %0d want 1", pkt_count);
        end
    endtask

    task automatic test_latency();
        logic [13:0] r;
        do_reset();
        tready  = 1'b1;
        pkt_len = 16'd0;
        enable  = 1'b1;
        @(negedge clk);
        send(14'($urandom), 1);
        r = 14'($urandom);
        @(negedge clk);
        s_data  = r;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        smp.push_back(r);
        n_cmp++;
        if (tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL latency early: got tvalid %b want 0", tvalid);
        end
        @(negedge clk);
        n_cmp++;
        if (tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL latency N+2: got tvalid %b want 1", tvalid);
        end
        repeat (6) send(14'($urandom), 1);
        wait_rx(4);
        build_model(0);
        cmp_words("len0");
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        do_reset();
        tready  = 1'b0;
        pkt_len = 16'd8;
        enable  = 1'b1;
        @(negedge clk);
        repeat (40) send(14'($urandom), 1);
        repeat (4) @(negedge clk);
        build_model(8);
        n_cmp++;
        if (overflow !== 1'b1 || drop_count !== 16'd4) begin
            n_err++;
            $display("FAIL bp drop: got ovf %b cnt %0d want 1 4", overflow, drop_count);
        end
        n_cmp++;
        if (pkt_count !== 16'd2) begin
            n_err++;
            $display("FAIL bp pkt_count: got %0d want 2", pkt_count);
        end
        held = tdata;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tvalid !== 1'b1 || tdata !== held || tdata !== exp_q[0][31:0]) begin
            n_err++;
            $display("FAIL bp hold: got %b %h want 1 %h", tvalid, tdata, exp_q[0][31:0]);
        end
        tready = 1'b1;
        wait_rx(16);
        exp_q = exp_q[0:15];
        cmp_words("bp drain");
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_cmp++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL bp clr: got ovf %b cnt %0d want 0 0", overflow, drop_count);
        end
    endtask

    task automatic test_disable();
        do_reset();
        tready  = 1'b1;
        pkt_len = 16'd8;
        enable  = 1'b1;
        @(negedge clk);
        repeat (6) send(14'($urandom), 1);
        enable = 1'b0;
        repeat (10) send(14'($urandom), 1);
        repeat (6) send(14'($urandom), 0);
        wait_rx(8);
        repeat (20) @(negedge clk);
        build_model(8);
        cmp_words("disable");
        n_cmp++;
        if (pkt_count !== 16'd1 || tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL disable end: got pkt %0d tvalid %b want 1 0", pkt_count, tvalid);
        end
    endtask

    task automatic test_full_boundary();
        logic [13:0] r;
        do_reset();
        tready  = 1'b0;
        pkt_len = 16'd4;
        enable  = 1'b1;
        @(negedge clk);
        repeat (32) send(14'($urandom), 1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tvalid !== 1'b1 || drop_count !== 16'd0 || pkt_count !== 16'd4) begin
            n_err++;
            $display("FAIL full fill: got %b %0d %0d want 1 0 4", tvalid, drop_count, pkt_count);
        end
        send(14'($urandom), 1);
        r = 14'($urandom);
        @(negedge clk);
        s_data  = r;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        tready  = 1'b1;
        smp.push_back(r);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (overflow !== 1'b0 || drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL full push+pop: got ovf %b cnt %0d want 0 0", overflow, drop_count);
        end
        wait_rx(17);
        build_model(4);
        cmp_words("full drain");
    endtask

    task automatic test_reset_mid();
        do_reset();
        tready  = 1'b0;
        pkt_len = 16'd8;
        enable  = 1'b1;
        @(negedge clk);
        repeat (10) send(14'($urandom), 1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tvalid !== 1'b1) begin
            n_err++;
            $display("FAIL rmid pre: got tvalid %b want 1", tvalid);
        end
        rst     = 1'b1;
        pkt_len = 16'd2;
        #1;
        n_cmp++;
        if (tvalid !== 1'b0 || pkt_count !== 16'd0 || drop_count !== 16'd0) begin
            n_err++;
            $display("FAIL rmid async: got %b %0d %0d want 0 0 0", tvalid, pkt_count, drop_count);
        end
        @(negedge clk);
        rst    = 1'b0;
        tready = 1'b1;
        rx.delete();
        smp.delete();
        @(negedge clk);
        repeat (8) send(14'($urandom), 1);
        wait_rx(4);
        build_model(2);
        cmp_words("rmid");
        n_cmp++;
        if (pkt_count !== 16'd2) begin
            n_err++;
            $display("FAIL rmid pkt_count: got %0d want 2", pkt_count);
        end
    endtask

    initial begin
        test_reset();
        test_packing();
        test_latency();
        test_backpressure();
        test_disable();
        test_full_boundary();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
